// File: rtl/tile_rom_arbiter_if.sv
// Bundle of the video fetch, CPU readback and SDRAM port signals seen by the
// tile ROM arbiter. The slave modport is the arbiter's view. The master modport
// is the view of the surrounding logic: the fetch path, the CPU and the SDRAM
// controller.
interface tile_rom_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_strobe;
    logic [DATA_W-1:0] vid_data;
    logic              vid_valid;
    logic              vid_late;
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_data;
    logic              cpu_ack;
    logic [ADDR_W-1:0] sdr_addr;
    logic              sdr_req;
    logic              sdr_ack;
    logic [DATA_W-1:0] sdr_dout;

    modport slave (
        input  vid_addr, vid_strobe, cpu_req, cpu_addr, sdr_ack, sdr_dout,
        output vid_data, vid_valid, vid_late, cpu_data, cpu_ack, sdr_addr, sdr_req
    );

    modport master (
        output vid_addr, vid_strobe, cpu_req, cpu_addr, sdr_ack, sdr_dout,
        input  vid_data, vid_valid, vid_late, cpu_data, cpu_ack, sdr_addr, sdr_req
    );
endinterface

// File: rtl/tile_rom_arbiter.sv
// Tile ROM arbiter. One SDRAM port is shared by the video fetch path and CPU
// ROM readback. Video wins arbitration, but a starvation counter forces a CPU
// grant after STARVE_LIMIT video grants in a row while the CPU waits. A
// one-entry cache of the last video fetch answers repeated addresses without
// touching SDRAM.
module tile_rom_arbiter #(
    parameter int ADDR_W       = 18,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic      clk,
    input  logic      reset,
    tile_rom_if.slave bus
);
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, VID_WAIT, CPU_WAIT} state_t;

    state_t state_q, state_d;

    logic              vid_pend_q, vid_pend_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [ADDR_W-1:0] latched_addr_q, latched_addr_d;
    logic              cache_valid_q, cache_valid_d;
    logic [ADDR_W-1:0] cache_addr_q, cache_addr_d;
    logic [DATA_W-1:0] cache_data_q, cache_data_d;
    logic              hold_valid_q, hold_valid_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [ADDR_W-1:0] sdr_addr_q, sdr_addr_d;
    logic              sdr_req_q, sdr_req_d;
    logic [DATA_W-1:0] vid_data_q, vid_data_d;
    logic              vid_valid_q, vid_valid_d;
    logic              vid_late_q, vid_late_d;
    logic [DATA_W-1:0] cpu_data_q, cpu_data_d;
    logic              cpu_ack_q, cpu_ack_d;

    // A cache hit does not depend on the arbiter state. It is checked against
    // the cache contents from before any fill in the same cycle.
    logic hit, miss, cpu_grant, vid_grant, vid_done, cpu_done;
    assign hit       = bus.vid_strobe && cache_valid_q && (bus.vid_addr == cache_addr_q);
    assign miss      = bus.vid_strobe && !hit;
    assign cpu_grant = (state_q == IDLE) && bus.cpu_req && (!vid_pend_q || (starve_q == LIMIT));
    assign vid_grant = (state_q == IDLE) && !cpu_grant && vid_pend_q;
    assign vid_done  = (state_q == VID_WAIT) && bus.sdr_ack;
    assign cpu_done  = (state_q == CPU_WAIT) && bus.sdr_ack;

    // State register; reset withdraws any SDRAM transaction immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state: arbitrate from IDLE, return on the SDRAM ack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (cpu_grant) state_d = CPU_WAIT;
                      else if (vid_pend_q) state_d = VID_WAIT;
            VID_WAIT: if (bus.sdr_ack) state_d = IDLE;
            CPU_WAIT: if (bus.sdr_ack) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output and datapath next values for every registered signal.
    always_comb begin
        vid_valid_d    = 1'b0;
        vid_data_d     = vid_data_q;
        hold_valid_d   = hold_valid_q;
        hold_data_d    = hold_data_q;
        vid_pend_d     = vid_pend_q && !vid_grant;
        pend_addr_d    = pend_addr_q;
        vid_late_d     = vid_late_q;
        latched_addr_d = latched_addr_q;
        cache_valid_d  = cache_valid_q;
        cache_addr_d   = cache_addr_q;
        cache_data_d   = cache_data_q;
        starve_d       = starve_q;
        sdr_addr_d     = sdr_addr_q;
        sdr_req_d      = sdr_req_q;
        cpu_data_d     = cpu_data_q;
        cpu_ack_d      = 1'b0;

        // Video output priority: SDRAM result, then held hit, then new hit.
        // A hit that cannot go out this cycle waits one cycle in the hold slot.
        if (vid_done) begin
            vid_valid_d = 1'b1;
            vid_data_d  = bus.sdr_dout;
            if (hit) begin
                hold_valid_d = 1'b1;
                hold_data_d  = cache_data_q;
            end
        end else if (hold_valid_q) begin
            vid_valid_d  = 1'b1;
            vid_data_d   = hold_data_q;
            hold_valid_d = hit;
            if (hit) hold_data_d = cache_data_q;
        end else if (hit) begin
            vid_valid_d = 1'b1;
            vid_data_d  = cache_data_q;
        end

        // A miss overwrites any unserved pending fetch. A fetch that is being
        // granted in this same cycle counts as served and does not make it late.
        if (miss) begin
            pend_addr_d = bus.vid_addr;
            vid_pend_d  = 1'b1;
            if (vid_pend_q && !vid_grant) vid_late_d = 1'b1;
        end

        if (cpu_grant) begin
            sdr_addr_d = bus.cpu_addr;
            sdr_req_d  = 1'b1;
            starve_d   = '0;
        end else if (vid_grant) begin
            sdr_addr_d     = pend_addr_q;
            sdr_req_d      = 1'b1;
            latched_addr_d = pend_addr_q;
            if (bus.cpu_req && (starve_q != LIMIT)) starve_d = starve_q + 1'b1;
        end

        if (vid_done) begin
            sdr_req_d     = 1'b0;
            cache_valid_d = 1'b1;
            cache_addr_d  = latched_addr_q;
            cache_data_d  = bus.sdr_dout;
        end

        // If the CPU withdrew its request, the read data is dropped.
        if (cpu_done) begin
            sdr_req_d = 1'b0;
            if (bus.cpu_req) begin
                cpu_data_d = bus.sdr_dout;
                cpu_ack_d  = 1'b1;
            end
        end
    end

    // Datapath and output registers; reset clears the cache as well.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vid_pend_q     <= 1'b0;
            pend_addr_q    <= '0;
            latched_addr_q <= '0;
            cache_valid_q  <= 1'b0;
            cache_addr_q   <= '0;
            cache_data_q   <= '0;
            hold_valid_q   <= 1'b0;
            hold_data_q    <= '0;
            starve_q       <= '0;
            sdr_addr_q     <= '0;
            sdr_req_q      <= 1'b0;
            vid_data_q     <= '0;
            vid_valid_q    <= 1'b0;
            vid_late_q     <= 1'b0;
            cpu_data_q     <= '0;
            cpu_ack_q      <= 1'b0;
        end else begin
            vid_pend_q     <= vid_pend_d;
            pend_addr_q    <= pend_addr_d;
            latched_addr_q <= latched_addr_d;
            cache_valid_q  <= cache_valid_d;
            cache_addr_q   <= cache_addr_d;
            cache_data_q   <= cache_data_d;
            hold_valid_q   <= hold_valid_d;
            hold_data_q    <= hold_data_d;
            starve_q       <= starve_d;
            sdr_addr_q     <= sdr_addr_d;
            sdr_req_q      <= sdr_req_d;
            vid_data_q     <= vid_data_d;
            vid_valid_q    <= vid_valid_d;
            vid_late_q     <= vid_late_d;
            cpu_data_q     <= cpu_data_d;
            cpu_ack_q      <= cpu_ack_d;
        end
    end

    assign bus.vid_data  = vid_data_q;
    assign bus.vid_valid = vid_valid_q;
    assign bus.vid_late  = vid_late_q;
    assign bus.cpu_data  = cpu_data_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.sdr_addr  = sdr_addr_q;
    assign bus.sdr_req   = sdr_req_q;
endmodule

// File: tb/tb_tile_rom_arbiter.sv
// Bench for tile_rom_arbiter: directed scenarios followed by a randomized phase.
// The bench plays the SDRAM controller with a fixed ROM image.
module tb_tile_rom_arbiter;
    logic clk;
    logic reset;

    tile_rom_if #(.ADDR_W(18), .DATA_W(32)) bus();

    tile_rom_arbiter #(.ADDR_W(18), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // SDRAM responder controls
    int resp_delay = 1;
    bit resp_rand  = 0;
    bit stray_req  = 0;
    bit vid_rnd_done = 0;

    // Observation queues filled by the monitor
    logic [17:0] grants[$];
    logic [31:0] vdat[$];
    logic [31:0] cdat[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rom_word(input logic [17:0] a);
        if (a == 18'h01234) return 32'hA5A5_5A5A;
        if (a == 18'h00ABC) return 32'hDEAD_BEEF;
        return 32'(a) * 32'h9E37_79B1;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] gat(input int i);
        return (i < grants.size()) ? grants[i] : 18'h3_FFFF;
    endfunction
    function automatic logic [31:0] vat(input int i);
        return (i < vdat.size()) ? vdat[i] : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] cat(input int i);
        return (i < cdat.size()) ? cdat[i] : 32'hFFFF_FFFF;
    endfunction

    // Video grants are those below the CPU address range used in the random phase.
    function automatic int vid_grant_cnt();
        int n = 0;
        foreach (grants[i]) if (grants[i] < 18'h20000) n++;
        return n;
    endfunction
    function automatic logic [17:0] last_vid_grant();
        logic [17:0] r = 18'h3_FFFF;
        foreach (grants[i]) if (grants[i] < 18'h20000) r = grants[i];
        return r;
    endfunction

    function automatic logic [127:0] outs();
        return {42'd0, bus.vid_data, bus.vid_valid, bus.vid_late, bus.cpu_data,
                bus.cpu_ack, bus.sdr_addr, bus.sdr_req};
    endfunction

    task automatic clear_q();
        grants.delete();
        vdat.delete();
        cdat.delete();
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic strobe(input logic [17:0] a);
        bus.vid_addr   = a;
        bus.vid_strobe = 1'b1;
        tick();
        bus.vid_strobe = 1'b0;
    endtask

    task automatic wait_vid(input int n_exp, input int budget, input string tag);
        int c = 0;
        while (vdat.size() < n_exp && c < budget) begin
            tick();
            c++;
        end
        if (vdat.size() < n_exp) chk({tag, "_timeout"}, vdat.size(), n_exp);
    endtask

    // SDRAM controller model: acks each request after a delay with the ROM word.
    initial begin
        int wait_cnt = -1;
        bus.sdr_ack  = 1'b0;
        bus.sdr_dout = '0;
        forever begin
            @(negedge clk);
            bus.sdr_ack = 1'b0;
            if (stray_req) begin
                bus.sdr_ack  = 1'b1;
                bus.sdr_dout = 32'h5555_AAAA;
                stray_req    = 0;
            end else if (bus.sdr_req) begin
                if (wait_cnt < 0) wait_cnt = resp_rand ? int'($urandom_range(0, 3)) : resp_delay;
                if (wait_cnt == 0) begin
                    bus.sdr_ack  = 1'b1;
                    bus.sdr_dout = rom_word(bus.sdr_addr);
                    wait_cnt     = -1;
                end else begin
                    wait_cnt--;
                end
            end else begin
                wait_cnt = -1;
            end
        end
    end

    // Monitor: records grants and output pulses, and checks that the address
    // stays stable while a request is held.
    initial begin
        logic        prev_req = 1'b0;
        logic [17:0] held     = '0;
        forever begin
            @(negedge clk);
            if (bus.sdr_req) begin
                if (!prev_req) begin
                    grants.push_back(bus.sdr_addr);
                    held = bus.sdr_addr;
                end else begin
                    chk("sdr_addr_stable", bus.sdr_addr, held);
                end
            end
            prev_req = bus.sdr_req;
            if (bus.vid_valid) vdat.push_back(bus.vid_data);
            if (bus.cpu_ack)   cdat.push_back(bus.cpu_data);
        end
    end

    task automatic vid_random();
        logic [17:0] model_addr  = 18'h00500;
        bit          model_valid = 1;
        for (int i = 0; i < 40; i++) begin
            logic [17:0] a;
            bit hit_exp;
            int g0, v0, lat;
            a       = 18'h00400 + 18'($urandom_range(0, 4));
            hit_exp = model_valid && (a == model_addr);
            g0      = vid_grant_cnt();
            v0      = vdat.size();
            strobe(a);
            lat = 1;
            while (vdat.size() == v0 && lat < 200) begin
                tick();
                lat++;
            end
            chk("rnd_vid_data", vat(v0), rom_word(a));
            if (hit_exp) begin
                chk("rnd_hit_latency", lat, 1);
                ticks(2);
                chk("rnd_hit_nofetch", vid_grant_cnt(), g0);
            end else begin
                chk("rnd_miss_latency_min", lat >= 3, 1);
                chk("rnd_miss_fetches", vid_grant_cnt(), g0 + 1);
                chk("rnd_miss_addr", last_vid_grant(), a);
            end
            model_addr  = a;
            model_valid = 1;
            ticks($urandom_range(0, 3));
        end
        vid_rnd_done = 1;
    endtask

    task automatic cpu_random();
        while (!vid_rnd_done) begin
            logic [17:0] ca;
            int c0, c;
            ticks($urandom_range(1, 4));
            if (vid_rnd_done) break;
            ca = 18'h20000 | 18'($urandom_range(0, 17'h1FFFF));
            bus.cpu_addr = ca;
            bus.cpu_req  = 1'b1;
            c0 = cdat.size();
            c  = 0;
            while (cdat.size() == c0 && c < 300) begin
                tick();
                c++;
            end
            bus.cpu_req = 1'b0;
            chk("rnd_cpu_data", cat(c0), rom_word(ca));
        end
    endtask

    initial begin
        logic [17:0] v[6];
        int c;
        bus.vid_addr   = '0;
        bus.vid_strobe = 1'b0;
        bus.cpu_req    = 1'b0;
        bus.cpu_addr   = '0;
        reset          = 1'b1;
        for (int i = 0; i < 6; i++) v[i] = 18'h00100 + 18'(i);

        // Reset state
        ticks(3);
        chk("reset_outputs", outs(), 128'd0);
        reset = 1'b0;
        tick();

        // Cold miss
        clear_q();
        resp_delay = 2;
        strobe(18'h01234);
        wait_vid(1, 30, "cold");
        ticks(4);
        chk("cold_grants", grants.size(), 1);
        chk("cold_addr", gat(0), 18'h01234);
        chk("cold_pulses", vdat.size(), 1);
        chk("cold_data", bus.vid_data, 32'hA5A5_5A5A);
        chk("cold_no_cpu_ack", cdat.size(), 0);

        // Cache hit
        clear_q();
        strobe(18'h01234);
        chk("hit_valid", bus.vid_valid, 1'b1);
        chk("hit_data", bus.vid_data, 32'hA5A5_5A5A);
        ticks(5);
        chk("hit_no_fetch", grants.size(), 0);
        chk("hit_pulses", vdat.size(), 1);

        // Starvation bound
        clear_q();
        resp_delay = 1;
        bus.cpu_addr = 18'h3_FFFF;
        strobe(v[0]);
        bus.cpu_req = 1'b1;
        begin
            int ns = 1, ngr = 0;
            c = 0;
            while (vdat.size() < 6 && c < 300) begin
                tick();
                c++;
                bus.vid_strobe = 1'b0;
                if (bus.cpu_ack) bus.cpu_req = 1'b0;
                if (grants.size() > ngr) begin
                    ngr = grants.size();
                    if (grants[ngr-1] != 18'h3_FFFF && ns < 6) begin
                        bus.vid_addr   = v[ns];
                        bus.vid_strobe = 1'b1;
                        ns++;
                    end
                end
            end
        end
        bus.vid_strobe = 1'b0;
        bus.cpu_req    = 1'b0;
        ticks(3);
        chk("starve_grant_cnt", grants.size(), 7);
        for (int i = 0; i < 4; i++) chk("starve_vid_first", gat(i), v[i]);
        chk("starve_cpu_grant", gat(4), 18'h3_FFFF);
        chk("starve_vid_rest0", gat(5), v[4]);
        chk("starve_vid_rest1", gat(6), v[5]);
        chk("starve_cpu_acks", cdat.size(), 1);
        chk("starve_cpu_data", cat(0), rom_word(18'h3_FFFF));
        for (int i = 0; i < 6; i++) chk("starve_vid_data", vat(i), rom_word(v[i]));

        // Late overwrite behind a CPU transaction
        clear_q();
        resp_delay   = 4;
        bus.cpu_addr = 18'h00ABD;
        bus.cpu_req  = 1'b1;
        tick();
        strobe(18'h00010);
        strobe(18'h00020);
        c = 0;
        while (vdat.size() < 1 && c < 100) begin
            tick();
            c++;
            if (bus.cpu_ack) bus.cpu_req = 1'b0;
        end
        bus.cpu_req = 1'b0;
        ticks(3);
        chk("late_grant_cnt", grants.size(), 2);
        chk("late_cpu_addr", gat(0), 18'h00ABD);
        chk("late_vid_addr", gat(1), 18'h00020);
        chk("late_vid_data", vat(0), rom_word(18'h00020));
        chk("late_flag", bus.vid_late, 1'b1);
        chk("late_cpu_data", cat(0), rom_word(18'h00ABD));

        // CPU abort
        clear_q();
        resp_delay   = 3;
        bus.cpu_addr = 18'h00ABC;
        bus.cpu_req  = 1'b1;
        tick();
        tick();
        bus.cpu_req = 1'b0;
        ticks(8);
        chk("abort_grant", gat(0), 18'h00ABC);
        chk("abort_no_ack", cdat.size(), 0);
        chk("abort_cpu_data", bus.cpu_data, rom_word(18'h00ABD));
        chk("abort_req_low", bus.sdr_req, 1'b0);
        strobe(18'h00200);
        wait_vid(1, 30, "abort_idle");
        chk("abort_then_vid_addr", gat(1), 18'h00200);
        chk("abort_then_vid_data", vat(0), rom_word(18'h00200));

        // Hit coinciding with a video ack: two separate pulses, ack result first
        clear_q();
        resp_delay = 3;
        strobe(18'h00500);
        c = 0;
        while (!bus.sdr_ack && c < 30) begin
            tick();
            c++;
        end
        chk("hold_ack_seen", bus.sdr_ack, 1'b1);
        bus.vid_addr   = 18'h00200;
        bus.vid_strobe = 1'b1;
        tick();
        bus.vid_strobe = 1'b0;
        chk("hold_first_valid", bus.vid_valid, 1'b1);
        chk("hold_first_data", bus.vid_data, rom_word(18'h00500));
        tick();
        chk("hold_second_valid", bus.vid_valid, 1'b1);
        chk("hold_second_data", bus.vid_data, rom_word(18'h00200));
        tick();
        chk("hold_done", bus.vid_valid, 1'b0);
        chk("hold_grants", grants.size(), 1);

        // Reset in the middle of a video fetch
        clear_q();
        resp_delay = 5;
        strobe(18'h00300);
        c = 0;
        while (!bus.sdr_req && c < 10) begin
            tick();
            c++;
        end
        tick();
        reset = 1'b1;
        #1;
        chk("rst_async_req", bus.sdr_req, 1'b0);
        chk("rst_mid_outputs", outs(), 128'd0);
        ticks(2);
        reset = 1'b0;
        vdat.delete();
        stray_req = 1;
        ticks(4);
        chk("stray_outputs", outs(), 128'd0);
        chk("stray_no_valid", vdat.size(), 0);
        grants.delete();
        resp_delay = 1;
        strobe(18'h00500);
        wait_vid(1, 30, "post_reset");
        chk("post_reset_miss", gat(0), 18'h00500);
        chk("post_reset_data", vat(0), rom_word(18'h00500));

        // Randomized traffic against the reference model
        ticks(3);
        clear_q();
        resp_rand = 1;
        fork
            vid_random();
            cpu_random();
        join
        ticks(5);
        chk("rnd_no_late", bus.vid_late, 1'b0);
        chk("rnd_idle_end", bus.sdr_req, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
